// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP core.
package jtag_tap_pkg;

  // IEEE 1149.1 TAP controller states, conventional 4-bit encoding.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic       BYPASS_CAPTURE  = 1'b0;
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  // Data register targeted by the active instruction.
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

endpackage

// File: rtl/jtag_ir_reg.sv
// Instruction register: shift stage plus the update (active) register.
// Ports: clk/rst_n; force_reset loads IDCODE_INSTR into ir_value;
// capture/shift/update strobes from the TAP FSM; tdi serial in;
// ir_value active instruction; shift_lsb serial out of the shift stage.
module jtag_ir_reg
  import jtag_tap_pkg::*;
#(
  parameter int unsigned         IR_WIDTH     = 5,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(5'h01)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                force_reset,
  input  logic                capture,
  input  logic                shift,
  input  logic                update,
  input  logic                tdi,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic                shift_lsb
);

  localparam logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(IR_CAPTURE_LSBS);

  logic [IR_WIDTH-1:0] ir_shift;

  // Shift stage: capture pattern, then right shift with tdi into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift <= CAPTURE_VAL;
    end else if (capture) begin
      ir_shift <= CAPTURE_VAL;
    end else if (shift) begin
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Active instruction; reset wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_value <= IDCODE_INSTR;
    end else if (force_reset) begin
      ir_value <= IDCODE_INSTR;
    end else if (update) begin
      ir_value <= ir_shift;
    end
  end

  assign shift_lsb = ir_shift[0];

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: 1149.1 state machine, IR, IDCODE/BYPASS DRs, user DR
// strobes and TDO muxing.
// Ports: clk/rst_n; tms/tdi/tdo/tdo_en pin side; state current TAP state;
// ir_value active instruction; tap_reset high in Test-Logic-Reset;
// user_sel/user_capture/user_shift/user_update strobes to user DRs;
// user_tdo serial outputs of the user DRs.
module jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter int unsigned         IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_563D,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(5'h01),
  parameter int unsigned         NUM_USER     = 2,
  parameter logic [IR_WIDTH-1:0] USER_BASE    = IR_WIDTH'(5'h10)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic                tap_reset,
  output logic [NUM_USER-1:0] user_sel,
  output logic                user_capture,
  output logic                user_shift,
  output logic                user_update,
  input  logic [NUM_USER-1:0] user_tdo
);

  localparam int unsigned CMP_W = IR_WIDTH + 1;

  tap_state_t  state_q, state_d;
  dr_sel_t     dr_sel;
  logic [31:0] idcode_sr;
  logic        bypass_q;
  logic        ir_lsb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TEST_LOGIC_RESET;
    else        state_q <= state_d;
  end

  // 1149.1 next-state function.
  always_comb begin
    state_d = TEST_LOGIC_RESET;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Forcing on entry to Test-Logic-Reset keeps ir_value = IDCODE_INSTR for
  // every cycle spent in that state, including the first.
  jtag_ir_reg #(
    .IR_WIDTH     (IR_WIDTH),
    .IDCODE_INSTR (IDCODE_INSTR)
  ) u_ir (
    .clk         (clk),
    .rst_n       (rst_n),
    .force_reset (state_d == TEST_LOGIC_RESET),
    .capture     (state_q == CAPTURE_IR),
    .shift       (state_q == SHIFT_IR),
    .update      (state_q == UPDATE_IR),
    .tdi         (tdi),
    .ir_value    (ir_value),
    .shift_lsb   (ir_lsb)
  );

  // Instruction decode; compared one bit wider so USER_BASE+i cannot wrap.
  always_comb begin
    dr_sel   = DR_BYPASS;
    user_sel = '0;
    if (ir_value == IDCODE_INSTR) begin
      dr_sel = DR_IDCODE;
    end else begin
      for (int i = 0; i < NUM_USER; i++) begin
        if (CMP_W'(ir_value) == CMP_W'(USER_BASE) + CMP_W'(i)) begin
          user_sel[i] = 1'b1;
          dr_sel      = DR_USER;
        end
      end
    end
  end

  // IDCODE and BYPASS registers, touched only when selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idcode_sr <= IDCODE_VAL;
      bypass_q  <= BYPASS_CAPTURE;
    end else if (state_q == CAPTURE_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= IDCODE_VAL;
      if (dr_sel == DR_BYPASS) bypass_q  <= BYPASS_CAPTURE;
    end else if (state_q == SHIFT_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= {tdi, idcode_sr[31:1]};
      if (dr_sel == DR_BYPASS) bypass_q  <= tdi;
    end
  end

  // TDO mux.
  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo    = ir_lsb;
      tdo_en = 1'b1;
    end else if (state_q == SHIFT_DR) begin
      tdo_en = 1'b1;
      unique case (dr_sel)
        DR_IDCODE: tdo = idcode_sr[0];
        DR_USER:   tdo = |(user_sel & user_tdo);
        default:   tdo = bypass_q;
      endcase
    end
  end

  assign state        = state_q;
  assign tap_reset    = (state_q == TEST_LOGIC_RESET);
  assign user_capture = (state_q == CAPTURE_DR) && (dr_sel == DR_USER);
  assign user_shift   = (state_q == SHIFT_DR)   && (dr_sel == DR_USER);
  assign user_update  = (state_q == UPDATE_DR)  && (dr_sel == DR_USER);

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised JTAG TAP core. It combines the IEEE 1149.1 16-state TAP state machine with:
- an IR_WIDTH-bit instruction register;
- the mandatory IDCODE and BYPASS data registers;
- NUM_USER externally implemented user data registers, driven through a strobe/select interface.

It sits between the pin-level JTAG interface (tms/tdi/tdo) and the debug-side data registers, and owns all TDO muxing.

## Interface
Parameters:
- IR_WIDTH, 5: instruction register width (≥2).
- IDCODE_VAL, 32'h1000_563D: IDCODE value; bit 0 must be 1.
- IDCODE_INSTR, 5'h01: opcode selecting IDCODE; IR reset value.
- NUM_USER, 2: number of user DR channels (1–8).
- USER_BASE, 5'h10: opcode of user channel 0; channel i uses USER_BASE+i.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  TCK-domain clock.
- rst_n  in  1  async active-low reset.
- tms  in  1  test mode select.
- tdi  in  1  test data in.
- tdo  out  1  test data out.
- tdo_en  out  1  high while in Shift-IR or Shift-DR.
- state  out  4  current tap_state_t.
- ir_value  out  IR_WIDTH  active (updated) instruction.
- tap_reset  out  1  high in Test-Logic-Reset.
- user_sel  out  NUM_USER  one-hot selected user channel; all zero otherwise.
- user_capture  out  1  Capture-DR with a user channel selected.
- user_shift  out  1  Shift-DR with a user channel selected.
- user_update  out  1  Update-DR with a user channel selected.
- user_tdo  in  NUM_USER  serial output (LSB) of each user DR.

## Operation
- FSM: standard 1149.1 transitions on the TMS value sampled at the clk rising edge.
  - Test-Logic-Reset stays while TMS=1 and exits to Run-Test/Idle on TMS=0.
  - Select-IR-Scan goes to Test-Logic-Reset on TMS=1.
  - Exit2 returns to Shift on TMS=0.
  - Unknown encodings go to Test-Logic-Reset.
  - Five consecutive TMS=1 edges reach Test-Logic-Reset from any state.
- IR:
  - Capture-IR loads the shift stage with {0…0, 2'b01}.
  - Each Shift-IR edge shifts right with tdi into the MSB.
  - Update-IR copies the shift stage to ir_value.
  - Test-Logic-Reset forces ir_value = IDCODE_INSTR.
- Decode:
  - ir_value == IDCODE_INSTR selects IDCODE.
  - USER_BASE ≤ ir_value < USER_BASE+NUM_USER selects user channel ir_value−USER_BASE.
  - Every other value, including all-ones, selects BYPASS.
- IDCODE DR (32 bits): Capture-DR loads IDCODE_VAL; Shift-DR shifts right with tdi into bit 31.
- BYPASS DR (1 bit): Capture-DR loads 0; Shift-DR loads tdi.
- User DR: the core holds no user data. Strobes are combinational from state and decode; user logic acts on the clk edge while the strobe is high.
- TDO (combinational):
  - Shift-IR: IR shift-stage LSB.
  - Shift-DR: LSB of the selected DR, or user_tdo[i].
  - Otherwise 0.

## Timing
- Reset values: state = Test-Logic-Reset; ir_value = IDCODE_INSTR; IR shift stage = {0…,01}; IDCODE shift reg = IDCODE_VAL; bypass = 0.
- Outputs under reset: tap_reset = 1; tdo = 0, tdo_en = 0; user_* = 0.
- rst_n assertion mid-scan aborts immediately, with no update applied.
- Capture: the edge leaving Capture-xR loads the register.
- Shift: each edge while in Shift-xR shifts one bit. The first TDO bit is therefore valid during the first Shift cycle, before any shift.
- N-bit scan: Capture, N cycles in Shift with TMS=0 on the first N−1 and TMS=1 on the last, then Exit1.
- Update: the edge leaving Update-IR changes ir_value, so the new decode is effective from Run-Test/Idle or Select-DR-Scan onward.
- Pause and Exit states hold all shift registers unchanged.
- The IR shift stage and the DR registers are never modified outside their own Capture/Shift states.

## Structure
- jtag_tap_pkg:
  - reuse tap_state_t and its 4-bit encoding;
  - add BYPASS_CAPTURE and IR_CAPTURE_LSBS (2'b01) constants;
  - add the dr_sel_t enum {DR_BYPASS, DR_IDCODE, DR_USER}.
- Sub-module: jtag_ir_reg (IR shift stage, update register, reset-to-IDCODE_INSTR). The FSM, decode, DRs and TDO mux stay in the top.

## Test plan
- Reset, then TMS 0,1,0,0 to Shift-DR, then 32 shifts with tdi=0 → tdo emits 32'h1000_563D LSB-first (first bit 1), and tdo_en is high for exactly 32 cycles.
- Shift IR 5'h1F, then Update, then shift DR with tdi pattern 1,0,1,1 → tdo emits 0,1,0,1 (one-cycle bypass delay), and ir_value = 5'h1F.
- IR scan of 5'h11 → tdo during the IR shift emits 1,0,0,0,0. Then a DR scan → user_sel = 2'b10; user_capture is high for 1 cycle, user_shift for N cycles, user_update for 1 cycle; tdo follows user_tdo[1].
- From Shift-DR, TMS=1 for 5 cycles → state = Test-Logic-Reset, tap_reset = 1, ir_value = 5'h01, user_sel = 0.
- Enter Pause-DR mid-IDCODE scan for 10 cycles, then resume via Exit2→Shift → the remaining bits continue with no loss or duplication.
- Assert rst_n low during Shift-IR after 3 bits of 5'h10 → after release, ir_value = 5'h01, and no user channel is ever selected.
